mux_scan_reg: RTL and testbench
===============================

Name: mux_scan_reg

Overview:
- Parametrised N:1 data selector with registered output; the next generation of the 4:1 gate-level channel mux.
- Two modes:
  - Direct: an external select picks the channel.
  - Scan: an internal counter walks all channels round-robin, holding each one for a programmable dwell.
- Sits between a bank of parallel sample channels and a single downstream consumer, such as a serialiser or monitor.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels, minimum 2.
- SEL_W, 2: select width, equal to clog2(CHANNELS).
- DWELL, 4: output samples taken per channel in scan mode before advancing, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, used in direct mode only.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  capture/advance enable.
- out  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index that produced the current out.
- out_valid  output  1  out was captured on the previous enabled cycle.
- wrap  output  1  one-cycle pulse when the scan completes its last channel and returns to channel 0.

Behaviour:
- Reset: rst is sampled at the clock edge. While it is high, the block clears:
  - out = 0, out_ch = 0, out_valid = 0, wrap = 0.
  - Internal ch_cnt = 0, dwell_cnt = 0.
  - State = DIRECT.
- Reset overrides everything, including a scan in progress. There is no partial-state retention.
- State machine has two states, DIRECT and SCAN.
- State transitions:
  - mode = 1 in DIRECT: go to SCAN next cycle, clear ch_cnt and dwell_cnt.
  - mode = 0 in SCAN: go to DIRECT next cycle, clear both counters.
  - A capture on a switching cycle uses the old state's rule.
- Latency: 1 cycle from in_bus/sel to out.
  - The output holds its value whenever no capture occurs.
  - out_valid is high only on the cycle after a capture.
- DIRECT, en = 1, sel < CHANNELS: out <= channel[sel], out_ch <= sel, out_valid <= 1.
- DIRECT, en = 1, sel >= CHANNELS (only possible when CHANNELS is not a power of 2):
  - out <= 0, out_ch <= sel, out_valid <= 0.
  - No X propagation is permitted.
- SCAN, en = 1: out <= channel[ch_cnt], out_ch <= ch_cnt, out_valid <= 1. Then:
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0 and ch_cnt advances.
  - Otherwise: dwell_cnt <= dwell_cnt + 1.
- Channel advance:
  - ch_cnt == CHANNELS-1 advances to 0 and wrap <= 1 for exactly one cycle, coincident with out_valid.
  - Otherwise ch_cnt <= ch_cnt + 1.
- en = 0 in any state:
  - Counters, out and out_ch hold.
  - out_valid <= 0, wrap <= 0.
  - The dwell is paused, not restarted.
- Counters never exceed their range, and ch_cnt never addresses a channel >= CHANNELS.
- wrap is 0 in DIRECT.
- in_bus changes are captured only on enabled edges. There is no internal buffering beyond the output register.

Optional Feature:
- Macro: MUX_SCAN_REG_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit): even parity (XOR reduction) of the data captured into out, registered in the same cycle as out.
  - Reset value 0.
  - Holds with out when no capture occurs.
  - In the DIRECT out-of-range case it is 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, CHANNELS=4, DWELL=2, and in_bus = {8'h44, 8'h33, 8'h22, 8'h11} (channel 0 = 8'h11) unless noted.
- Reset: hold rst=1 for 2 cycles with mode=1, en=1.
  - Required: out=0, out_ch=0, out_valid=0, wrap=0.
  - After release with mode=1, the first capture is 8'h11 from ch 0.
- Direct select: mode=0, en=1, sel = 2, then 0, then 3 on consecutive cycles.
  - Required: out = 8'h33, 8'h11, 8'h44 one cycle later each, out_ch matching, out_valid=1.
  - Then en=0: out holds 8'h44 and out_valid=0.
- Scan sequence: mode=1, en=1 for 8 cycles.
  - Required: out = 11,11,22,22,33,33,44,44 with out_ch = 0,0,1,1,2,2,3,3.
  - wrap=1 only with the second 8'h44.
  - Next capture is 8'h11.
- Scan pause: in scan, drop en for 3 cycles after the first 8'h22 capture.
  - Required: out_valid=0 and out=8'h22 during the pause.
  - On resume, the next capture is 8'h22, completing the dwell, then 8'h33.
- Mode and reset mid-scan:
  - Switch mode to 0 after capturing 8'h33 with sel=1. Required: next capture 8'h22 from direct.
  - Return to mode=1. Required: the scan restarts at ch 0 (8'h11).
  - Assert rst mid-dwell. Required: all outputs are 0 the next cycle.
- Parity (MUX_SCAN_REG_PARITY_EN defined): direct-select 8'h33, then 8'h11, then 8'h07.
  - 8'h07 is applied by setting in_bus channel 1 = 8'h07 with sel=1.
  - Required: out_par = 0, then 0, then 1.

Source files
------------

// File: rtl/mux_scan_reg.sv
// N:1 channel selector with registered output. It has a direct mode (an external select)
// and a scan mode (round-robin with a dwell). Define MUX_SCAN_REG_PARITY_EN to add out_par.
module mux_scan_reg #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int DWELL    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic                      en,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
`ifdef MUX_SCAN_REG_PARITY_EN
   output logic                      out_par,
`endif
   output logic                      wrap
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic {DIRECT = 1'b0, SCAN = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ch_cnt, ch_nxt;
   logic [DW_W-1:0]    dwell_cnt, dwell_nxt;
   logic [WIDTH-1:0]   chan [CHANNELS];
   logic [WIDTH-1:0]   dir_data, scan_data, cap_data;
   logic               dir_hit;
   logic [SEL_W-1:0]   cap_ch;
   logic               cap, cap_vld, wrap_nxt;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign chan[k] = in_bus[k*WIDTH +: WIDTH];
   end

   // Compare-based muxes: an out-of-range select matches nothing and yields zero, never X.
   always_comb begin
      dir_data  = '0;
      dir_hit   = 1'b0;
      scan_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) begin
            dir_data = chan[k];
            dir_hit  = 1'b1;
         end
         if (ch_cnt == SEL_W'(k)) scan_data = chan[k];
      end
   end

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch_cnt;
      dwell_nxt = dwell_cnt;
      cap       = 1'b0;
      cap_data  = '0;
      cap_ch    = ch_cnt;
      cap_vld   = 1'b0;
      wrap_nxt  = 1'b0;
      case (state)
         DIRECT: begin
            if (en) begin
               cap     = 1'b1;
               cap_ch  = sel;
               cap_vld = dir_hit;
               if (dir_hit) cap_data = dir_data;
            end
            if (mode) begin
               state_nxt = SCAN;
               ch_nxt    = '0;
               dwell_nxt = '0;
            end
         end
         SCAN: begin
            if (en) begin
               cap      = 1'b1;
               cap_data = scan_data;
               cap_ch   = ch_cnt;
               cap_vld  = 1'b1;
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_nxt = '0;
                  if (ch_cnt == LAST_CH) begin
                     ch_nxt   = '0;
                     wrap_nxt = 1'b1;
                  end else begin
                     ch_nxt = ch_cnt + 1'b1;
                  end
               end else begin
                  dwell_nxt = dwell_cnt + 1'b1;
               end
            end
            // Leaving scan restarts the walk from channel 0 next time.
            if (!mode) begin
               state_nxt = DIRECT;
               ch_nxt    = '0;
               dwell_nxt = '0;
            end
         end
         default: state_nxt = DIRECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DIRECT;
         ch_cnt    <= '0;
         dwell_cnt <= '0;
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
`ifdef MUX_SCAN_REG_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         ch_cnt    <= ch_nxt;
         dwell_cnt <= dwell_nxt;
         out_valid <= cap_vld;
         wrap      <= wrap_nxt;
         if (cap) begin
            out    <= cap_data;
            out_ch <= cap_ch;
`ifdef MUX_SCAN_REG_PARITY_EN
            out_par <= ^cap_data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Random and directed bench for mux_scan_reg: a 4-channel instance (dwell 2) and a 3-channel
// instance (dwell 3, so an out-of-range select is possible), both checked against a flat-position model.
module tb_mux_scan_reg;

   logic        clk = 1'b0;
   logic        rst, mode, en;
   logic [1:0]  sel;
   logic [31:0] bus0;
   logic [23:0] bus1;
   logic [7:0]  out0, out1;
   logic [1:0]  out_ch0, out_ch1;
   logic        vld0, vld1, wrap0, wrap1;
`ifdef MUX_SCAN_REG_PARITY_EN
   logic        par0, par1;
`endif

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mux_scan_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut0 (
      .clk(clk), .rst(rst), .in_bus(bus0), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_REG_PARITY_EN
      .out_par(par0),
`endif
      .out(out0), .out_ch(out_ch0), .out_valid(vld0), .wrap(wrap0));

   mux_scan_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut1 (
      .clk(clk), .rst(rst), .in_bus(bus1), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_REG_PARITY_EN
      .out_par(par1),
`endif
      .out(out1), .out_ch(out_ch1), .out_valid(vld1), .wrap(wrap1));

   // The scan is a single position pos = channel*dwell + step, walking 0 .. nch*dw-1.
   typedef struct {
      bit         scan;
      int         pos;
      logic [7:0] out;
      int         och;
      bit         vld;
      bit         wrp;
      bit         par;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t step(mdl_t m, int nch, int dw, logic [31:0] bus,
                                 int s, bit md, bit e, bit r);
      mdl_t n = m;
      int   c;
      if (r) begin
         n.scan = 0; n.pos = 0; n.out = 0; n.och = 0; n.vld = 0; n.wrp = 0; n.par = 0;
         return n;
      end
      n.vld = 0;
      n.wrp = 0;
      if (e) begin
         if (!m.scan) begin
            n.och = s;
            if (s < nch) begin
               n.out = bus[s*8 +: 8];
               n.vld = 1;
            end else begin
               n.out = 0;
            end
         end else begin
            c     = m.pos / dw;
            n.out = bus[c*8 +: 8];
            n.och = c;
            n.vld = 1;
            n.pos = (m.pos + 1) % (nch * dw);
            n.wrp = (n.pos == 0);
         end
         n.par = ^n.out;
      end
      if (md != m.scan) begin
         n.scan = md;
         n.pos  = 0;
      end
      return n;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m0 = step(m0, 4, 2, bus0, int'(sel), mode, en, rst);
      m1 = step(m1, 3, 3, {8'h00, bus1}, int'(sel), mode, en, rst);
      @(negedge clk);
      chk("out0",  32'(out0),    32'(m0.out));
      chk("ch0",   32'(out_ch0), 32'(m0.och));
      chk("vld0",  32'(vld0),    32'(m0.vld));
      chk("wrap0", 32'(wrap0),   32'(m0.wrp));
      chk("out1",  32'(out1),    32'(m1.out));
      chk("ch1",   32'(out_ch1), 32'(m1.och));
      chk("vld1",  32'(vld1),    32'(m1.vld));
      chk("wrap1", 32'(wrap1),   32'(m1.wrp));
`ifdef MUX_SCAN_REG_PARITY_EN
      chk("par0",  32'(par0),    32'(m0.par));
      chk("par1",  32'(par1),    32'(m1.par));
`endif
   endtask

   logic [7:0] seq [8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

   initial begin
      rst = 1; mode = 1; en = 1; sel = 0;
      bus0 = 32'h44332211; bus1 = 24'h332211;
      tick(); tick();
      chk("rst_out", 32'(out0), 0);
      chk("rst_vld", 32'(vld0), 0);
      chk("rst_wrap", 32'(wrap0), 0);

      // First edge after reset is still in direct (sel=0), then the scan walks from ch 0.
      rst = 0;
      tick();
      chk("first", 32'(out0), 32'h11);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("scan_out",  32'(out0),    32'(seq[i]));
         chk("scan_ch",   32'(out_ch0), i / 2);
         chk("scan_wrap", 32'(wrap0),   (i == 7) ? 1 : 0);
      end
      tick();
      chk("scan_next", 32'(out0), 32'h11);

      tick(); tick();
      chk("pre_pause", 32'(out0), 32'h22);
      en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_out", 32'(out0), 32'h22);
         chk("pause_vld", 32'(vld0), 0);
      end
      en = 1;
      tick();
      chk("resume", 32'(out0), 32'h22);
      tick();
      chk("advance", 32'(out0), 32'h33);

      // Switching edge still captures by the scan rule; direct takes over after it.
      mode = 0; sel = 1;
      tick();
      tick();
      chk("to_direct", 32'(out0), 32'h22);
      sel = 2; tick(); chk("dir_2", 32'(out0), 32'h33); chk("dir_ch2", 32'(out_ch0), 2);
      sel = 0; tick(); chk("dir_0", 32'(out0), 32'h11);
      sel = 3; tick(); chk("dir_3", 32'(out0), 32'h44); chk("dir1_oor", 32'(out1), 0);
      chk("dir1_oor_vld", 32'(vld1), 0);
      en = 0; tick(); chk("hold", 32'(out0), 32'h44); chk("hold_vld", 32'(vld0), 0);

      en = 1; mode = 1;
      tick();
      tick();
      chk("rescan", 32'(out0), 32'h11);
      tick(); tick();
      rst = 1;
      tick();
      chk("mid_rst_out", 32'(out0), 0);
      chk("mid_rst_ch",  32'(out_ch0), 0);
      rst = 0;

`ifdef MUX_SCAN_REG_PARITY_EN
      mode = 0; en = 1; bus0 = 32'h44332211;
      tick();
      sel = 2; tick(); chk("par_33", 32'(par0), 0);
      sel = 0; tick(); chk("par_11", 32'(par0), 0);
      bus0[15:8] = 8'h07; sel = 1; tick(); chk("par_07", 32'(par0), 1);
`endif

      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         en   = ($urandom_range(0, 3) != 0);
         sel  = 2'($urandom);
         bus0 = $urandom;
         bus1 = 24'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
